// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the instruction-memory address, pairs returning
// words with their PC and hands them to decode over a valid/ready handshake.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      state, state_next;
    logic [31:0] pc_q, pc_next;
    logic        vld_q, vld_next;
    logic        fault_q, fault_next;
    logic [31:0] cnt_q;
    logic        transfer;
    logic        redirect_ok;

    assign redirect_ok = redirect_valid && (redirect_pc[1:0] == 2'b00);

    assign if_pc       = pc_q;
    assign if_instr    = imem_instr;
    assign if_valid    = vld_q && (state == RUN) && !redirect_valid && !halt_req && !reset;
    assign transfer    = if_valid && if_ready;
    assign fault       = fault_q;
    assign fetch_count = cnt_q;

    // imem_addr is the address whose word becomes visible next cycle; it always
    // equals pc_next so the returning data lines up with pc_q.
    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        vld_next   = vld_q;
        fault_next = fault_q;
        imem_addr  = pc_q;
        unique case (state)
            BOOT: begin
                imem_addr  = RESET_PC;
                pc_next    = RESET_PC;
                vld_next   = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (redirect_ok) begin
                    imem_addr = redirect_pc;
                    pc_next   = redirect_pc;
                    vld_next  = 1'b1;
                end else if (redirect_valid) begin
                    state_next = HALT;
                    vld_next   = 1'b0;
                    fault_next = 1'b1;
                end else if (halt_req) begin
                    state_next = HALT;
                    vld_next   = 1'b0;
                end else if (transfer) begin
                    imem_addr = pc_q + 32'd4;
                    pc_next   = pc_q + 32'd4;
                end
            end
            HALT: begin
                if (redirect_ok) begin
                    imem_addr  = redirect_pc;
                    pc_next    = redirect_pc;
                    vld_next   = 1'b1;
                    fault_next = 1'b0;
                    state_next = RUN;
                end else if (redirect_valid) begin
                    fault_next = 1'b1;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
        if (reset) begin
            imem_addr = RESET_PC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= BOOT;
            pc_q    <= RESET_PC;
            vld_q   <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_next;
            pc_q    <= pc_next;
            vld_q   <= vld_next;
            fault_q <= fault_next;
            if (transfer) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the instruction memory (1024 x 32 synchronous BRAM, word index = address[11:2], one-cycle read latency, no read enable). It generates the fetch address each cycle, pairs returning instruction words with their PC, and presents them to decode over a valid/ready handshake. It handles stalls by replaying the current address, handles redirects (branch/jump) by killing the in-flight word, and supports halt and misaligned-target fault.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_addr  out  32  byte address to instruction memory, combinational from state and inputs
imem_instr  in  32  memory read data for the address presented in the previous cycle
if_valid  out  1  if_pc/if_instr hold a live instruction
if_ready  in  1  decode accepts this cycle; transfer = if_valid & if_ready
if_pc  out  32  PC of the presented instruction
if_instr  out  32  presented instruction; equals imem_instr
redirect_valid  in  1  redirect the fetch stream to redirect_pc
redirect_pc  in  32  redirect target
halt_req  in  1  stop fetching until the next redirect
fault  out  1  set when a misaligned redirect is taken
fetch_count  out  32  count of accepted transfers

Behaviour:
- State: FSM {BOOT, RUN, HALT}; pc_q (address whose data is on imem_instr); vld_q; fault_q; cnt_q.
- Reset: state=BOOT, pc_q=RESET_PC, vld_q=0, fault_q=0, cnt_q=0. During reset: if_valid=0, if_pc=RESET_PC, imem_addr=RESET_PC, fault=0, fetch_count=0.
- if_pc=pc_q; if_instr=imem_instr; if_valid = vld_q & (state==RUN) & ~redirect_valid & ~halt_req.
- BOOT (one cycle): imem_addr=RESET_PC; next pc_q=RESET_PC, vld_q=1, state=RUN. The first if_valid occurs in the 2nd cycle after reset deasserts.
- RUN, priority order:
  1. redirect_valid with redirect_pc[1:0]==0: imem_addr=redirect_pc; next pc_q=redirect_pc, vld_q=1. The current word is killed (no transfer this cycle).
  2. redirect_valid with redirect_pc[1:0]!=0: imem_addr=pc_q; next state=HALT, vld_q=0, fault_q=1, pc_q unchanged.
  3. halt_req: imem_addr=pc_q; next state=HALT, vld_q=0. No transfer this cycle.
  4. Transfer: imem_addr=pc_q+4; next pc_q=pc_q+4 (modulo 2^32).
  5. Otherwise (stall): imem_addr=pc_q, which replays the same word, so if_instr stays stable next cycle.
- HALT: if_valid=0; imem_addr=pc_q. An aligned redirect_valid goes to RUN exactly as in RUN case 1 and clears fault_q. A misaligned redirect stays in HALT with fault_q=1. halt_req is ignored.
- Stability: while if_valid=1 and if_ready=0 with no redirect/halt, if_pc and if_instr hold on the next cycle.
- cnt_q increments by 1 on each transfer and wraps at 2^32. fault=fault_q.
- redirect and halt asserted together: redirect wins. Reset mid-stream: all state returns to reset values on the next edge and the in-flight word is discarded.
- The memory aliases every 4 KiB (pc 0x1000 reads word 0); pc_q is still kept at the full 32 bits.

Test Plan:
- Reset released, if_ready=1, memory word k = 0xA000_0000+k → if_valid rises 2nd cycle; if_pc = 0x0,0x4,0x8…; if_instr = 0xA0000000,0xA0000001…; fetch_count=3 after 3 transfers.
- Stall: drop if_ready for 3 cycles while if_pc=0x8 → imem_addr=0x8, and if_pc/if_instr hold 0x8/0xA0000002; resume → next is 0xC, no word lost or duplicated.
- Redirect to 0x100 while if_pc=0x10 and if_ready=1 → no transfer that cycle; next cycle if_pc=0x100, if_instr=0xA0000040; count not incremented for 0x10.
- Misaligned redirect 0x102 → fault=1, if_valid=0 indefinitely; then redirect 0x200 → fault=0, if_pc=0x200 next cycle.
- halt_req pulse at if_pc=0x20 → if_valid=0 from that cycle; halt_req and redirect 0x40 together in a later cycle → fetch resumes at 0x40.
- Wrap: RESET_PC=0xFFFF_FFFC → if_pc 0xFFFFFFFC then 0x0; assert reset mid-stall → if_valid=0, fetch_count=0, restart at RESET_PC.
